// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - issue/write-back bundle between the register file and muldiv_unit
//   start, op, a, b, dst      : request side, driven by the issue logic (master)
//   busy                      : unit occupied, start ignored
//   write, wreg, wd           : register-file write port, driven by the unit (slave)
//   done, dz                  : completion pulse and divide-by-zero flag
interface muldiv_unit_if #(
  parameter int WIDTH     = 16,
  parameter int REGS_LOG2 = 3
);
  logic                 start;
  logic [1:0]           op;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [REGS_LOG2-1:0] dst;
  logic                 busy;
  logic                 write;
  logic [REGS_LOG2-1:0] wreg;
  logic [WIDTH-1:0]     wd;
  logic                 done;
  logic                 dz;

  modport master (
    output start, op, a, b, dst,
    input  busy, write, wreg, wd, done, dz
  );

  modport slave (
    input  start, op, a, b, dst,
    output busy, write, wreg, wd, done, dz
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative 16-bit multiply/divide unit writing both result halves to the register file
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : muldiv_unit_if slave (start/op/a/b/dst in; busy/write/wreg/wd/done/dz out)
//   op   : 00 MULU, 01 MULS, 10 DIVU, 11 DIVS
module muldiv_unit #(
  parameter int WIDTH     = 16,
  parameter int REGS_LOG2 = 3
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, CALC, WB_LO, WB_HI} state_t;

  localparam logic [4:0] LAST_STEP = 5'(WIDTH - 1);

  state_t               state_q, state_d;
  logic [4:0]           cnt_q;
  logic [1:0]           op_q;
  logic [REGS_LOG2-1:0] dst_q;
  logic [WIDTH-1:0]     opb_q;     // multiplicand / divisor magnitude
  logic [WIDTH-1:0]     hi_q;      // partial product high / partial remainder
  logic [WIDTH-1:0]     lo_q;      // multiplier shifting out / quotient shifting in
  logic [WIDTH-1:0]     a_q;       // original dividend, returned as remainder on divide by zero
  logic                 dz_q;
  logic                 neg_lo_q;  // negate product (MUL) or quotient (DIV)
  logic                 neg_hi_q;  // negate remainder (DIVS with negative dividend)

  logic accept, last_step, is_signed;
  assign accept    = (state_q == IDLE) && bus.start;
  assign last_step = (state_q == CALC) && (cnt_q == LAST_STEP);
  assign is_signed = bus.op[0];

  logic [WIDTH-1:0] mag_a, mag_b;
  assign mag_a = (is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign mag_b = (is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // One iteration: shift-add for multiply, restoring shift-subtract for divide.
  // The partial remainder stays below the divisor, so div_diff fits in WIDTH bits when taken.
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi, step_lo;
  assign mul_sum   = lo_q[0] ? ({1'b0, hi_q} + {1'b0, opb_q}) : {1'b0, hi_q};
  assign div_shift = {hi_q, lo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opb_q};
  assign div_ge    = div_shift >= {1'b0, opb_q};

  always_comb begin
    step_hi = '0;
    step_lo = '0;
    if (op_q[1]) begin
      step_hi = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      {step_hi, step_lo} = {mul_sum, lo_q[WIDTH-1:1]};
    end
  end

  // Sign fix-up and divide-by-zero override applied on the final step.
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   fin_hi, fin_lo;
  assign prod_neg = -{step_hi, step_lo};

  always_comb begin
    fin_hi = step_hi;
    fin_lo = step_lo;
    if (dz_q) begin
      fin_lo = '1;
      fin_hi = a_q;
    end else if (op_q[1]) begin
      if (neg_lo_q) fin_lo = -step_lo;
      if (neg_hi_q) fin_hi = -step_hi;
    end else if (neg_lo_q) begin
      {fin_hi, fin_lo} = prod_neg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = CALC;
      CALC:    if (last_step) state_d = WB_LO;
      WB_LO:   state_d = WB_HI;
      WB_HI:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      op_q     <= '0;
      dst_q    <= '0;
      opb_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      a_q      <= '0;
      dz_q     <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
    end else if (accept) begin
      cnt_q    <= '0;
      op_q     <= bus.op;
      dst_q    <= bus.dst;
      opb_q    <= mag_b;
      hi_q     <= '0;
      lo_q     <= mag_a;
      a_q      <= bus.a;
      dz_q     <= bus.op[1] && (bus.b == '0);
      neg_lo_q <= is_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      neg_hi_q <= is_signed && bus.op[1] && bus.a[WIDTH-1];
    end else if (state_q == CALC) begin
      cnt_q <= cnt_q + 5'd1;
      if (last_step) begin
        hi_q <= fin_hi;
        lo_q <= fin_lo;
      end else begin
        hi_q <= step_hi;
        lo_q <= step_lo;
      end
    end
  end

  assign bus.busy = (state_q != IDLE);

  always_comb begin
    bus.write = 1'b0;
    bus.wreg  = '0;
    bus.wd    = '0;
    bus.done  = 1'b0;
    bus.dz    = 1'b0;
    case (state_q)
      WB_LO: begin
        bus.write = 1'b1;
        bus.wreg  = dst_q;
        bus.wd    = lo_q;
      end
      WB_HI: begin
        bus.write = 1'b1;
        bus.wreg  = dst_q + REGS_LOG2'(1);
        bus.wd    = hi_q;
        bus.done  = 1'b1;
        bus.dz    = dz_q;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit (vector table, random ops vs arithmetic model, robustness sequences)
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(16), .REGS_LOG2(3)) bus ();
  muldiv_unit #(.WIDTH(16), .REGS_LOG2(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  dst;
    logic [15:0] lo;
    logic [15:0] hi;
    logic        dz;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference arithmetic straight from the operation definitions.
  function automatic void model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] lo, output logic [15:0] hi, output logic dz);
    int sa, sb, q, r;
    logic [31:0] up;
    sa = int'($signed(a));
    sb = int'($signed(b));
    dz = 1'b0;
    lo = '0;
    hi = '0;
    case (op)
      2'd0: begin
        up = 32'(a) * 32'(b);
        lo = up[15:0];
        hi = up[31:16];
      end
      2'd1: begin
        q  = sa * sb;
        lo = q[15:0];
        hi = q[31:16];
      end
      default: begin
        if (b == 16'd0) begin
          lo = 16'hFFFF;
          hi = a;
          dz = 1'b1;
        end else if (op == 2'd2) begin
          lo = a / b;
          hi = a % b;
        end else begin
          q  = sa / sb;
          r  = sa % sb;
          lo = q[15:0];
          hi = r[15:0];
        end
      end
    endcase
  endfunction

  // Issue one op and watch cycles E0..E18; poke_at >= 0 re-pulses start with junk operands at that cycle.
  task automatic run_op(input vec_t v, input string tag, input int poke_at);
    logic [15:0] got_lo, got_hi;
    logic [2:0]  wr_lo, wr_hi;
    logic        got_dz, exp_busy, exp_write, exp_done;
    bit          timing_ok;
    got_lo = '0; got_hi = '0; wr_lo = '0; wr_hi = '0; got_dz = 1'b0;
    timing_ok = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = v.op;
    bus.a     = v.a;
    bus.b     = v.b;
    bus.dst   = v.dst;
    @(posedge clk);
    for (int c = 0; c <= 18; c++) begin
      @(negedge clk);
      exp_busy  = (c < 18);
      exp_write = (c == 16) || (c == 17);
      exp_done  = (c == 17);
      if (bus.busy !== exp_busy || bus.write !== exp_write || bus.done !== exp_done) timing_ok = 1'b0;
      if (c != 17 && bus.dz !== 1'b0) timing_ok = 1'b0;
      if (!exp_write && (bus.wreg !== 3'd0 || bus.wd !== 16'd0)) timing_ok = 1'b0;
      if (c == 16) begin got_lo = bus.wd; wr_lo = bus.wreg; end
      if (c == 17) begin got_hi = bus.wd; wr_hi = bus.wreg; got_dz = bus.dz; end
      if (c == 0) begin
        bus.start = 1'b0;
        bus.a     = 16'($urandom);
        bus.b     = 16'($urandom);
        bus.dst   = 3'($urandom);
      end
      if (c == poke_at) begin
        bus.start = 1'b1;
        bus.op    = 2'($urandom);
        bus.a     = 16'($urandom);
        bus.b     = 16'($urandom);
        bus.dst   = 3'($urandom);
      end
      if (c == poke_at + 1) bus.start = 1'b0;
    end
    check($sformatf("%s_timing", tag), 32'(timing_ok), 32'd1);
    check($sformatf("%s_lo", tag), 32'(got_lo), 32'(v.lo));
    check($sformatf("%s_hi", tag), 32'(got_hi), 32'(v.hi));
    check($sformatf("%s_wreg_lo", tag), 32'(wr_lo), 32'(v.dst));
    check($sformatf("%s_wreg_hi", tag), 32'(wr_hi), 32'(3'(v.dst + 3'd1)));
    check($sformatf("%s_dz", tag), 32'(got_dz), 32'(v.dz));
  endtask

  vec_t tbl[8];
  vec_t rv;
  bit   saw_write;

  initial begin
    tbl[0] = '{op: 2'd0, a: 16'hFFFF, b: 16'hFFFF, dst: 3'd2, lo: 16'h0001, hi: 16'hFFFE, dz: 1'b0};
    tbl[1] = '{op: 2'd1, a: 16'hFFFE, b: 16'h0003, dst: 3'd4, lo: 16'hFFFA, hi: 16'hFFFF, dz: 1'b0};
    tbl[2] = '{op: 2'd2, a: 16'd100,  b: 16'd7,    dst: 3'd7, lo: 16'h000E, hi: 16'h0002, dz: 1'b0};
    tbl[3] = '{op: 2'd3, a: 16'hFFF9, b: 16'h0002, dst: 3'd1, lo: 16'hFFFD, hi: 16'hFFFF, dz: 1'b0};
    tbl[4] = '{op: 2'd3, a: 16'h8000, b: 16'hFFFF, dst: 3'd3, lo: 16'h8000, hi: 16'h0000, dz: 1'b0};
    tbl[5] = '{op: 2'd2, a: 16'h1234, b: 16'h0000, dst: 3'd5, lo: 16'hFFFF, hi: 16'h1234, dz: 1'b1};
    tbl[6] = '{op: 2'd3, a: 16'hFFF9, b: 16'h0000, dst: 3'd0, lo: 16'hFFFF, hi: 16'hFFF9, dz: 1'b1};
    tbl[7] = '{op: 2'd1, a: 16'h8000, b: 16'h8000, dst: 3'd6, lo: 16'h0000, hi: 16'h4000, dz: 1'b0};

    bus.start = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;
    bus.dst   = '0;
    repeat (2) @(negedge clk);
    check("rst_busy",  32'(bus.busy),  32'd0);
    check("rst_write", 32'(bus.write), 32'd0);
    check("rst_done",  32'(bus.done),  32'd0);
    check("rst_dz",    32'(bus.dz),    32'd0);
    check("rst_wreg",  32'(bus.wreg),  32'd0);
    check("rst_wd",    32'(bus.wd),    32'd0);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) run_op(tbl[i], $sformatf("vec%0d", i), -1);

    // A start pulse at E5 must neither be queued nor disturb the running op.
    run_op(tbl[0], "ignore_start", 4);
    run_op(tbl[3], "after_ignore", -1);

    for (int i = 0; i < 40; i++) begin
      rv.op  = 2'($urandom_range(0, 3));
      rv.a   = 16'($urandom);
      rv.b   = 16'($urandom);
      rv.dst = 3'($urandom);
      if (i % 7 == 3) rv.b = 16'h0000;
      if (i % 11 == 5) begin rv.a = 16'h8000; rv.b = 16'hFFFF; end
      model(rv.op, rv.a, rv.b, rv.lo, rv.hi, rv.dz);
      run_op(rv, $sformatf("rnd%0d", i), -1);
    end

    // Asynchronous reset at E8 aborts the op without any write-back.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'd0;
    bus.a     = 16'h1111;
    bus.b     = 16'h2222;
    bus.dst   = 3'd1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("abort_busy",  32'(bus.busy),  32'd0);
    check("abort_write", 32'(bus.write), 32'd0);
    saw_write = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.write !== 1'b0 || bus.busy !== 1'b0) saw_write = 1'b1;
    end
    rst = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.write !== 1'b0 || bus.busy !== 1'b0) saw_write = 1'b1;
    end
    check("abort_no_write", 32'(saw_write), 32'd0);

    rv = '{op: 2'd0, a: 16'd3, b: 16'd5, dst: 3'd6, lo: 16'h000F, hi: 16'h0000, dz: 1'b0};
    run_op(rv, "post_reset", -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 16-bit multiply/divide execution unit sitting directly downstream of the 8×16 register file. It accepts two operands taken from the file's `rd1`/`rd2` read ports, computes a 32-bit product or a quotient/remainder pair over 16 cycles, then drives the file's single write port for two consecutive cycles to store both result halves. It provides `busy` so the issue logic stalls behind it.

## Interface
Parameters:
- `WIDTH`, 16, operand and result-half width; the design is verified only at 16.
- `REGS_LOG2`, 3, register-index width.

Ports:
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `start`  input  1  request; sampled only in IDLE.
- `op`  input  2  00 MULU, 01 MULS, 10 DIVU, 11 DIVS.
- `a`  input  16  operand A / dividend, from `rd1`.
- `b`  input  16  operand B / divisor, from `rd2`.
- `dst`  input  3  destination register index.
- `busy`  output  1  unit is occupied; `start` is ignored.
- `write`  output  1  register-file write strobe.
- `wreg`  output  3  register-file write index.
- `wd`  output  16  register-file write data.
- `done`  output  1  one-cycle pulse on the final write-back cycle.
- `dz`  output  1  divide-by-zero flag, valid only with `done`.

## Operation
- States: IDLE, CALC, WB_LO, WB_HI.
- IDLE with `start`=1 at an edge: latch `op`, `a`, `b`, `dst`; clear the 5-bit iteration counter; go to CALC. Later changes on `a`/`b`/`dst` have no effect.
- CALC performs one shift-add (multiply) or one restoring shift-subtract (divide) step per edge. After the 16th step it goes to WB_LO.
- Signed ops convert operands to magnitudes at accept and fix signs when leaving CALC.
- WB_LO: `write`=1, `wreg`=`dst`, `wd`=low half. Then go to WB_HI.
- WB_HI: `write`=1, `wreg`=(`dst`+1) mod 8, `wd`=high half, `done`=1. Then go to IDLE.
- Result halves:
  - MUL: low = product[15:0], high = product[31:16].
  - DIV: low = quotient, high = remainder.
- MULU: unsigned 16×16→32. MULS: two's-complement 16×16→32.
- DIVU: unsigned. DIVS: quotient truncates toward zero; the remainder takes the dividend's sign.
- DIVS -32768/-1: quotient 0x8000, remainder 0x0000, `dz`=0.
- Divide by zero (`b`=0, DIVU or DIVS): quotient 0xFFFF, remainder = original `a`, `dz`=1. Latency is unchanged.
- `dst`=7 wraps: the high half is written to r0.
- `dst` equal to a source register is legal, because operands are already latched.
- `start` while `busy`=1 is ignored, not queued.

## Timing
- Reset values: state IDLE; `busy`, `write`, `done`, `dz` = 0; `wreg`=0; `wd`=0.
- Reset asserted mid-operation clears all state immediately, asynchronously. No write-back occurs. After release the unit is in IDLE.
- Outside WB_LO/WB_HI: `write`=0, `wreg`=0, `wd`=0. `done` and `dz` are 0 except in WB_HI.
- Cycle timing, with E0 the accepting edge:
  - CALC during E0..E16.
  - WB_LO between E16 and E17.
  - WB_HI between E17 and E18.
  - IDLE from E18.
- Total: 18 cycles from accept to idle.
- `busy`=1 from E0 until E18, including both write-back cycles.
- Earliest next accept is E18, which gives back-to-back throughput of one op per 18 cycles.
- `write` is high for exactly 2 consecutive cycles per op. The register file captures data at E17 and E18.
- All outputs are registered or decoded from state only. There is no combinational path from `start`/`a`/`b` to any output.

## Test plan
- MULU a=0xFFFF, b=0xFFFF, dst=2:
  - r2 ← 0x0001 at E17 and r3 ← 0xFFFE at E18.
  - `done` high only in cycle E17–E18; `busy` low after E18.
- MULS a=0xFFFE (-2), b=0x0003, dst=4: r4 ← 0xFFFA, r5 ← 0xFFFF.
- DIVU a=100, b=7, dst=7: r7 ← 0x000E, then r0 ← 0x0002 (wrap); `dz`=0.
- DIVS a=0xFFF9 (-7), b=0x0002: quotient 0xFFFD, remainder 0xFFFF.
- DIVS a=0x8000, b=0xFFFF: quotient 0x8000, remainder 0x0000.
- DIVU a=0x1234, b=0: quotient 0xFFFF, remainder 0x1234; `dz`=1 with `done`; latency 18.
- Robustness:
  - Pulse `start` with different operands at E5: it is ignored and results match the first op.
  - Drop `rst` to 0 at E8: `busy`/`write` fall immediately and no write ever occurs.
  - After reset release, a new MULU 3×5 writes 0x000F / 0x0000.
